// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity, stop period.
// Built-in baud divider produces one oversample tick every DVSR clocks (16 ticks per bit).
module uart_tx_core #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8,
  parameter int PARITY  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx
);

  localparam int S_W = 6;
  localparam int N_W = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [S_W-1:0]    s, s_next;
  logic [N_W-1:0]    n, n_next;
  logic [DBIT-1:0]   b, b_next;
  logic              par_bit, par_next;
  logic [DVSR_W-1:0] div;
  logic              tick;
  logic              accept;
  logic              tx_next;
  logic              done_next;

  // Handshake: tx_start is a request with an implicit ready of (state == S_IDLE);
  // a request is taken on any rising edge where both hold, otherwise it is dropped.
  assign accept  = (state == S_IDLE) && tx_start;
  assign tick    = (div == DVSR_W'(DVSR - 1));
  assign tx_busy = (state != S_IDLE);

  // Divider restarts on accept so every bit edge lands a whole number of bits after it.
  always_ff @(posedge clk) begin
    if (reset || accept || tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      par_bit      <= 1'b0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_next;
      s            <= s_next;
      n            <= n_next;
      b            <= b_next;
      par_bit      <= par_next;
      tx           <= tx_next;
      tx_done_tick <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    par_next   = par_bit;
    unique case (state)
      S_IDLE: begin
        if (tx_start) begin
          state_next = S_START;
          s_next     = '0;
          n_next     = '0;
          b_next     = din[DBIT-1:0];
          par_next   = (PARITY == 2) ? ~(^din[DBIT-1:0]) : ^din[DBIT-1:0];
        end
      end
      S_START: begin
        if (tick) begin
          if (s == S_W'(15)) begin
            s_next     = '0;
            state_next = S_DATA;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (s == S_W'(15)) begin
            s_next = '0;
            b_next = b >> 1;
            if (n == N_W'(DBIT - 1)) begin
              state_next = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              n_next = n + 1'b1;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          if (s == S_W'(15)) begin
            s_next     = '0;
            state_next = S_STOP;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (s == S_W'(SB_TICK - 1)) begin
            state_next = S_IDLE;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Line level is computed from the upcoming state so tx is a clean register output.
  always_comb begin
    tx_next   = 1'b1;
    done_next = (state == S_STOP) && (state_next == S_IDLE);
    unique case (state_next)
      S_IDLE:  tx_next = 1'b1;
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = b_next[0];
      S_PAR:   tx_next = par_next;
      S_STOP:  tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: four instances (no parity, even, odd, 2 stop bits) at DVSR=4,
// a serial-line monitor decodes each frame and checks it against an expected queue.
module tb_uart_tx_core;

  localparam int W = 21;  // {has_par, len[10:0], par, data[7:0]}

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] start_v;
  logic [7:0] din_v [4];
  wire  [3:0] tx_v;
  wire  [3:0] busy_v;
  wire  [3:0] done_v;

  int sel = 0;
  int tests = 0;
  int fails = 0;
  int done_cnt [4] = '{default: 0};
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_core #(.DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_W(3), .PARITY(0)) u0 (
    .clk(clk), .reset(reset), .tx_start(start_v[0]), .din(din_v[0]),
    .tx_busy(busy_v[0]), .tx_done_tick(done_v[0]), .tx(tx_v[0]));
  uart_tx_core #(.DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_W(3), .PARITY(1)) u1 (
    .clk(clk), .reset(reset), .tx_start(start_v[1]), .din(din_v[1]),
    .tx_busy(busy_v[1]), .tx_done_tick(done_v[1]), .tx(tx_v[1]));
  uart_tx_core #(.DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_W(3), .PARITY(2)) u2 (
    .clk(clk), .reset(reset), .tx_start(start_v[2]), .din(din_v[2]),
    .tx_busy(busy_v[2]), .tx_done_tick(done_v[2]), .tx(tx_v[2]));
  uart_tx_core #(.DBIT(8), .SB_TICK(32), .DVSR(4), .DVSR_W(3), .PARITY(0)) u3 (
    .clk(clk), .reset(reset), .tx_start(start_v[3]), .din(din_v[3]),
    .tx_busy(busy_v[3]), .tx_done_tick(done_v[3]), .tx(tx_v[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic hp, input int len, input logic p,
                                      input logic [7:0] d);
    return {hp, 11'(len), p, d};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_v[i] === 1'b1) done_cnt[i]++;
    end
  end

  // Monitor: decode one frame from the selected line, sampling mid-bit.
  initial begin : monitor
    logic [11:0]  bits;
    logic [W-1:0] e;
    logic         stop_ok;
    logic         aborted;
    int           t;
    int           nb;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx_v[sel] === 1'b0 && busy_v[sel] === 1'b1) begin
        t       = 0;
        bits    = '0;
        stop_ok = 1'b1;
        aborted = 1'b0;
        nb      = (sel == 1 || sel == 2) ? 10 : 9;
        while (done_v[sel] !== 1'b1 && !aborted && t < 3000) begin
          @(negedge clk);
          t++;
          if (done_v[sel] !== 1'b1 && busy_v[sel] !== 1'b1) begin
            aborted = 1'b1;
          end else if (done_v[sel] !== 1'b1) begin
            if (t % 64 == 32 && t / 64 < nb) bits[t/64] = tx_v[sel];
            if (t >= nb * 64 && tx_v[sel] !== 1'b1) stop_ok = 1'b0;
          end
        end
        if (!aborted) begin
          if (t >= 3000) begin
            check("frame_timeout", 32'(t), 32'd0);
          end else if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'(bits), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("start_bit", 32'(bits[0]), 32'd0);
            check("data", 32'(bits[8:1]), 32'(e[7:0]));
            if (e[20]) check("parity", 32'(bits[9]), 32'(e[8]));
            check("frame_len", 32'(t), 32'(e[19:9]));
            check("stop_level", 32'(stop_ok), 32'd1);
          end
        end
      end
    end
  end

  task automatic send(input int s, input logic [7:0] d);
    @(posedge clk);
    #1;
    din_v[s]   = d;
    start_v[s] = 1'b1;
    @(posedge clk);
    #1;
    start_v[s] = 1'b0;
    check("start_low", 32'(tx_v[s]), 32'd0);
    check("busy_high", 32'(busy_v[s]), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin : stimulus
    int c0;
    int bad;
    logic seen;
    reset   = 1'b1;
    start_v = '0;
    for (int i = 0; i < 4; i++) din_v[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset
    check("reset_tx", 32'(tx_v), 32'hF);
    check("reset_busy", 32'(busy_v), 32'h0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // Plain 8N1 frame
    sel = 0;
    c0  = done_cnt[0];
    exp_q.push_back(mk(1'b0, 640, 1'b0, 8'hA5));
    send(0, 8'hA5);
    wait_drain(1000);
    check("done_once", 32'(done_cnt[0] - c0), 32'd1);

    // Parity variants
    sel = 1;
    exp_q.push_back(mk(1'b1, 704, 1'b0, 8'hA5));
    send(1, 8'hA5);
    wait_drain(1000);
    sel = 2;
    exp_q.push_back(mk(1'b1, 704, 1'b0, 8'h01));
    send(2, 8'h01);
    wait_drain(1000);
    sel = 1;
    exp_q.push_back(mk(1'b1, 704, 1'b1, 8'h01));
    send(1, 8'h01);
    wait_drain(1000);

    // Held tx_start gives back-to-back frames; pulses while busy are dropped
    sel = 0;
    c0  = done_cnt[0];
    exp_q.push_back(mk(1'b0, 640, 1'b0, 8'h55));
    @(posedge clk);
    #1;
    din_v[0]   = 8'h55;
    start_v[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) seen = 1'b1;
    end
    check("b2b_done_seen", 32'(seen), 32'd1);
    din_v[0] = 8'h0F;
    exp_q.push_back(mk(1'b0, 640, 1'b0, 8'h0F));
    @(posedge clk);
    #1;
    check("b2b_start", 32'(tx_v[0]), 32'd0);
    start_v[0] = 1'b0;
    for (int p = 0; p < 3; p++) begin
      repeat (100) @(posedge clk);
      #1;
      din_v[0]   = 8'hFF;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      din_v[0]   = 8'h00;
    end
    wait_drain(1500);
    check("b2b_done_count", 32'(done_cnt[0] - c0), 32'd2);

    // Reset mid-frame abandons the frame
    c0 = done_cnt[0];
    send(0, 8'h00);
    repeat (298) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tx", 32'(tx_v[0]), 32'd1);
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("abort_no_done", 32'(done_cnt[0] - c0), 32'd0);
    exp_q.push_back(mk(1'b0, 640, 1'b0, 8'h3C));
    send(0, 8'h3C);
    wait_drain(1000);
    check("after_abort_done", 32'(done_cnt[0] - c0), 32'd1);

    // Two stop bits
    sel = 3;
    c0  = done_cnt[3];
    exp_q.push_back(mk(1'b0, 704, 1'b0, 8'hFF));
    send(3, 8'hFF);
    wait_drain(1000);
    check("sb32_done", 32'(done_cnt[3] - c0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
